// File: rtl/step_pulse_gen.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, one-cycle step pulse and press counter.
// Optional auto-repeat while held is compiled in with STEP_AUTO_REPEAT_EN.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W         = 8,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_raw,
  input  logic               enable,
  output logic               step_pulse,
  output logic               btn_level,
  output logic [COUNT_W-1:0] press_count
);

  // state        | meaning
  // IDLE         | button released and stable
  // PRESS_WAIT   | btn_sync high, counting towards acceptance
  // PRESSED      | press accepted, button held
  // RELEASE_WAIT | btn_sync low, counting towards release
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             s2;

`ifdef STEP_AUTO_REPEAT_EN
  localparam int                RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      step_pulse  <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= '0;
`ifdef STEP_AUTO_REPEAT_EN
      rpt         <= '0;
`endif
    end else begin
      s1         <= btn_raw;
      s2         <= s1;
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
            cnt       <= '0;
`ifdef STEP_AUTO_REPEAT_EN
            rpt       <= '0;
`endif
            // A press accepted while disabled is dropped for good.
            if (enable) begin
              step_pulse  <= 1'b1;
              press_count <= press_count + COUNT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
`ifdef STEP_AUTO_REPEAT_EN
          else if (rpt == RPT_LAST) begin
            rpt <= '0;
            if (enable) begin
              step_pulse  <= 1'b1;
              press_count <= press_count + COUNT_W'(1);
            end
          end else begin
            rpt <= rpt + RPT_W'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state <= PRESSED;
            cnt   <= '0;
`ifdef STEP_AUTO_REPEAT_EN
            rpt   <= '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          btn_level <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
